// File: rtl/check_pkg.sv
// Shared constants, state encoding and sizing helper for the check_pack result checker.
package check_pkg;

  localparam int unsigned SC_CMD_IDLE    = 0;
  localparam int unsigned SC_CMD_BITMASK = 1;
  localparam int unsigned SC_CMD_CLR_CNT = 2;
  localparam int unsigned SC_CMD_MODE    = 3;

  localparam int unsigned META_RUN_BIT  = 7;
  localparam int unsigned META_MODE_BIT = 1;
  localparam int unsigned META_FAIL_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2,
    WB   = 2'd3
  } state_t;

  // Number of memory words needed to hold one packed record.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/check_pack_sat_counter.sv
// Saturating up-counter; a clear beats a same-cycle increment.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  // Count register: clear first, then increment unless already at all ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/check_pack.sv
// Pops a result and an {expected, address} record, compares them under a mask and
// writes the masked result plus a meta byte to memory over an Avalon-MM master.
module check_pack
  import check_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RTF_WIDTH  = 24,
  parameter int CHF_WIDTH  = RTF_WIDTH + ADDR_WIDTH,
  parameter int META_WIDTH = 8,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic                  mem_waitrequest,
  input  logic [RTF_WIDTH-1:0]  rfifo_data,
  output logic                  rfifo_rdreq,
  input  logic                  rfifo_rdempty,
  input  logic [CHF_WIDTH-1:0]  cfifo_data,
  output logic                  cfifo_rdreq,
  input  logic                  cfifo_rdempty,
  input  logic [SCC_WIDTH-1:0]  sc_cmd,
  input  logic [SCD_WIDTH-1:0]  sc_data,
  output logic                  sc_ready,
  output logic [CNT_WIDTH-1:0]  vec_count,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  localparam int RES_WORDS = int'(ceil_div(RTF_WIDTH + META_WIDTH, DATA_WIDTH));
  localparam int REC_WIDTH = RES_WORDS * DATA_WIDTH;
  localparam int IDX_WIDTH = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RES_WORDS - 1);

  state_t                state_r;
  logic [RTF_WIDTH-1:0]  mask_r;
  logic                  fail_only_r;
  logic [REC_WIDTH-1:0]  rec_r;
  logic [IDX_WIDTH-1:0]  word_idx_r;

  logic [RTF_WIDTH-1:0]  res_s;
  logic [RTF_WIDTH-1:0]  exp_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  fail_s;
  logic [META_WIDTH-1:0] meta_s;
  logic [REC_WIDTH-1:0]  rec_s;
  logic [REC_WIDTH-1:0]  rec_next_s;
  logic                  cmp_s;
  logic                  clr_s;

  // Masked compare and record packing; the pad bits fall out of the shift as zeros.
  always_comb begin
    res_s  = rfifo_data & mask_r;
    exp_s  = cfifo_data[CHF_WIDTH-1 -: RTF_WIDTH] & mask_r;
    addr_s = cfifo_data[ADDR_WIDTH-1:0];
    fail_s = (res_s != exp_s);
    meta_s = '0;
    meta_s[META_RUN_BIT]  = 1'b1;
    meta_s[META_MODE_BIT] = fail_only_r;
    meta_s[META_FAIL_BIT] = fail_s;
    rec_s = REC_WIDTH'(res_s) << (REC_WIDTH - RTF_WIDTH);
    rec_s[META_WIDTH-1:0] = meta_s;
    rec_next_s = rec_r << DATA_WIDTH;
    cmp_s = (state_r == CMP);
    clr_s = (sc_cmd == SCC_WIDTH'(SC_CMD_CLR_CNT));
  end

  assign mem_byteenable = '1;
  assign sc_ready       = (state_r == IDLE) & rfifo_rdempty & cfifo_rdempty;

  // Record FSM with registered memory and FIFO handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      mem_write     <= 1'b0;
      rfifo_rdreq   <= 1'b0;
      cfifo_rdreq   <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      rec_r         <= '0;
      word_idx_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!rfifo_rdempty && !cfifo_rdempty) begin
            state_r     <= RD;
            rfifo_rdreq <= 1'b1;
            cfifo_rdreq <= 1'b1;
          end
        end
        RD: begin
          rfifo_rdreq <= 1'b0;
          cfifo_rdreq <= 1'b0;
          state_r     <= CMP;
        end
        CMP: begin
          rec_r      <= rec_s;
          word_idx_r <= '0;
          if (fail_only_r && !fail_s) begin
            state_r <= IDLE;
          end else begin
            state_r       <= WB;
            mem_write     <= 1'b1;
            mem_address   <= addr_s;
            mem_writedata <= rec_s[REC_WIDTH-1 -: DATA_WIDTH];
          end
        end
        WB: begin
          // Word k always sits in the top slot of rec_r, so it stays put under stall.
          if (!mem_waitrequest) begin
            if (word_idx_r == LAST_IDX) begin
              state_r   <= IDLE;
              mem_write <= 1'b0;
            end else begin
              word_idx_r    <= word_idx_r + IDX_WIDTH'(1);
              mem_address   <= mem_address + ADDR_WIDTH'(1);
              mem_writedata <= rec_next_s[REC_WIDTH-1 -: DATA_WIDTH];
              rec_r         <= rec_next_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          mem_write   <= 1'b0;
          rfifo_rdreq <= 1'b0;
          cfifo_rdreq <= 1'b0;
        end
      endcase
    end
  end

  // STIM command decode for the compare mask and fail-only mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_r      <= '1;
      fail_only_r <= 1'b0;
    end else begin
      case (sc_cmd)
        SCC_WIDTH'(SC_CMD_BITMASK): mask_r      <= sc_data[RTF_WIDTH-1:0];
        SCC_WIDTH'(SC_CMD_MODE):    fail_only_r <= sc_data[0];
        default: begin
          mask_r      <= mask_r;
          fail_only_r <= fail_only_r;
        end
      endcase
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_vec_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (cmp_s),
    .clr   (clr_s),
    .count (vec_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fail_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (cmp_s & fail_s),
    .clr   (clr_s),
    .count (fail_count)
  );

endmodule

// File: tb/tb_check_pack.sv
// Scoreboard bench for check_pack: default build plus a 40-bit, 4-bit-counter build.
module tb_check_pack;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1;

  logic [19:0] m0_addr;  logic [1:0] m0_be;  logic m0_write;  logic [15:0] m0_wdata;
  logic        m0_wait = 1'b0;
  logic [23:0] r0_data = '0;  logic r0_rdreq;  logic r0_empty = 1'b1;
  logic [43:0] c0_data = '0;  logic c0_rdreq;  logic c0_empty = 1'b1;
  logic [4:0]  sc0_cmd = '0;  logic [23:0] sc0_data = '0;  logic sc0_ready;
  logic [15:0] vec0, fail0;

  logic [19:0] m1_addr;  logic [1:0] m1_be;  logic m1_write;  logic [15:0] m1_wdata;
  logic        m1_wait = 1'b0;
  logic [39:0] r1_data = '0;  logic r1_rdreq;  logic r1_empty = 1'b1;
  logic [59:0] c1_data = '0;  logic c1_rdreq;  logic c1_empty = 1'b1;
  logic [4:0]  sc1_cmd = '0;  logic [39:0] sc1_data = '0;  logic sc1_ready;
  logic [3:0]  vec1, fail1;

  check_pack dut0 (
    .clock(clock), .reset(reset),
    .mem_address(m0_addr), .mem_byteenable(m0_be), .mem_write(m0_write),
    .mem_writedata(m0_wdata), .mem_waitrequest(m0_wait),
    .rfifo_data(r0_data), .rfifo_rdreq(r0_rdreq), .rfifo_rdempty(r0_empty),
    .cfifo_data(c0_data), .cfifo_rdreq(c0_rdreq), .cfifo_rdempty(c0_empty),
    .sc_cmd(sc0_cmd), .sc_data(sc0_data), .sc_ready(sc0_ready),
    .vec_count(vec0), .fail_count(fail0)
  );

  check_pack #(.RTF_WIDTH(40), .SCD_WIDTH(40), .CNT_WIDTH(4)) dut1 (
    .clock(clock), .reset(reset),
    .mem_address(m1_addr), .mem_byteenable(m1_be), .mem_write(m1_write),
    .mem_writedata(m1_wdata), .mem_waitrequest(m1_wait),
    .rfifo_data(r1_data), .rfifo_rdreq(r1_rdreq), .rfifo_rdempty(r1_empty),
    .cfifo_data(c1_data), .cfifo_rdreq(c1_rdreq), .cfifo_rdempty(c1_empty),
    .sc_cmd(sc1_cmd), .sc_data(sc1_data), .sc_ready(sc1_ready),
    .vec_count(vec1), .fail_count(fail1)
  );

  int errors = 0;
  int checks = 0;
  logic [35:0] exp0q[$];
  logic [35:0] exp1q[$];
  logic [23:0] r0q[$];
  logic [43:0] c0q[$];
  logic [39:0] r1q[$];
  logic [59:0] c1q[$];
  logic pend0 = 1'b0, pend1 = 1'b0;
  int acc0 = 0, acc1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // One clock of FIFO service: data appears the cycle after rdreq.
  task automatic cyc();
    @(posedge clock);
    #1;
    if (pend0 && r0q.size() > 0) begin
      r0_data = r0q.pop_front();
      c0_data = c0q.pop_front();
    end
    pend0 = r0_rdreq;
    if (pend1 && r1q.size() > 0) begin
      r1_data = r1q.pop_front();
      c1_data = c1q.pop_front();
    end
    pend1 = r1_rdreq;
    r0_empty = (r0q.size() == 0);
    c0_empty = (c0q.size() == 0);
    r1_empty = (r1q.size() == 0);
    c1_empty = (c1q.size() == 0);
  endtask

  task automatic push0(input logic [23:0] res, input logic [23:0] expv, input logic [19:0] addr);
    r0q.push_back(res);
    c0q.push_back({expv, addr});
    r0_empty = 1'b0;
    c0_empty = 1'b0;
  endtask

  task automatic push1(input logic [39:0] res, input logic [39:0] expv, input logic [19:0] addr);
    r1q.push_back(res);
    c1q.push_back({expv, addr});
    r1_empty = 1'b0;
    c1_empty = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    do begin cyc(); n++; end while (!(sc0_ready && exp0q.size() == 0) && n < 200);
    if (n >= 200) timeout("idle0");
  endtask

  task automatic wait_idle1();
    int n = 0;
    do begin cyc(); n++; end while (!(sc1_ready && exp1q.size() == 0) && n < 200);
    if (n >= 200) timeout("idle1");
  endtask

  task automatic wait_write0();
    int n = 0;
    do begin cyc(); n++; end while (!m0_write && n < 50);
    if (n >= 50) timeout("write0");
  endtask

  task automatic stim0(input logic [4:0] cmd, input logic [23:0] data);
    sc0_cmd  = cmd;
    sc0_data = data;
    cyc();
    sc0_cmd  = 5'd0;
    sc0_data = 24'd0;
  endtask

  logic        st0_v = 1'b0;
  logic [35:0] st0_q;
  logic [35:0] e0;
  // Monitor for dut0: stall stability, then pop-and-compare on every accepted write.
  always @(negedge clock) begin
    if (m0_write) begin
      if (st0_v) begin
        chk("stall_addr0", 64'(m0_addr), 64'(st0_q[35:16]));
        chk("stall_data0", 64'(m0_wdata), 64'(st0_q[15:0]));
      end
      if (m0_wait) begin
        st0_v = 1'b1;
        st0_q = {m0_addr, m0_wdata};
      end else begin
        st0_v = 1'b0;
        acc0++;
        if (exp0q.size() == 0) begin
          timeout("unexpected_write0");
        end else begin
          e0 = exp0q.pop_front();
          chk("wr_addr0", 64'(m0_addr), 64'(e0[35:16]));
          chk("wr_data0", 64'(m0_wdata), 64'(e0[15:0]));
        end
      end
    end else begin
      st0_v = 1'b0;
    end
  end

  logic [35:0] e1;
  // Monitor for dut1 (never stalled).
  always @(negedge clock) begin
    if (m1_write && !m1_wait) begin
      acc1++;
      if (exp1q.size() == 0) begin
        timeout("unexpected_write1");
      end else begin
        e1 = exp1q.pop_front();
        chk("wr_addr1", 64'(m1_addr), 64'(e1[35:16]));
        chk("wr_data1", 64'(m1_wdata), 64'(e1[15:0]));
      end
    end
  end

  initial begin
    int a0;
    int n;
    logic [39:0] res1;

    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_write0", 64'(m0_write), 64'd0);
    chk("rst_addr0", 64'(m0_addr), 64'd0);
    chk("rst_data0", 64'(m0_wdata), 64'd0);
    chk("rst_rdreq0", 64'({r0_rdreq, c0_rdreq}), 64'd0);
    chk("rst_cnt0", 64'({vec0, fail0}), 64'd0);
    chk("rst_ready0", 64'(sc0_ready), 64'd1);
    chk("byteenable0", 64'(m0_be), 64'h3);
    chk("rst_write1", 64'(m1_write), 64'd0);

    // Matching record.
    exp0q.push_back({20'h00100, 16'hABCD});
    exp0q.push_back({20'h00101, 16'hEF80});
    push0(24'hABCDEF, 24'hABCDEF, 20'h00100);
    wait_idle0();
    chk("t1_vec", 64'(vec0), 64'd1);
    chk("t1_fail", 64'(fail0), 64'd0);
    chk("t1_ready", 64'(sc0_ready), 64'd1);

    // Mismatch in bit 0.
    exp0q.push_back({20'h00300, 16'h1234});
    exp0q.push_back({20'h00301, 16'h5681});
    push0(24'h123456, 24'h123457, 20'h00300);
    wait_idle0();
    chk("t2_vec", 64'(vec0), 64'd2);
    chk("t2_fail", 64'(fail0), 64'd1);

    // Mask off bit 0: the result is masked too.
    stim0(5'd1, 24'hFFFFFE);
    exp0q.push_back({20'h00380, 16'h1234});
    exp0q.push_back({20'h00381, 16'h5680});
    push0(24'h123457, 24'h123456, 20'h00380);
    wait_idle0();
    chk("t3_vec", 64'(vec0), 64'd3);
    chk("t3_fail", 64'(fail0), 64'd1);

    // Fail-only mode: the passing record writes nothing.
    stim0(5'd3, 24'd1);
    a0 = acc0;
    push0(24'h111110, 24'h111111, 20'h00400);
    wait_idle0();
    chk("t4_nowrite", 64'(acc0 - a0), 64'd0);
    exp0q.push_back({20'h00200, 16'hAAAA});
    exp0q.push_back({20'h00201, 16'hAA83});
    push0(24'hAAAAAA, 24'h555554, 20'h00200);
    wait_idle0();
    chk("t4_writes", 64'(acc0 - a0), 64'd2);
    chk("t4_vec", 64'(vec0), 64'd5);
    chk("t4_fail", 64'(fail0), 64'd2);
    stim0(5'd3, 24'd0);

    // Five stalled cycles on word 0.
    m0_wait = 1'b1;
    a0 = acc0;
    exp0q.push_back({20'h00500, 16'h0F0F});
    exp0q.push_back({20'h00501, 16'h0E80});
    push0(24'h0F0F0F, 24'h0F0F0F, 20'h00500);
    wait_write0();
    repeat (5) cyc();
    m0_wait = 1'b0;
    wait_idle0();
    chk("t5_accepts", 64'(acc0 - a0), 64'd2);
    chk("t5_vec", 64'(vec0), 64'd6);

    // CLR_CNT on the CMP cycle beats the increments.
    exp0q.push_back({20'h00600, 16'hF000});
    exp0q.push_back({20'h00601, 16'h0081});
    push0(24'hF00000, 24'h000000, 20'h00600);
    n = 0;
    do begin cyc(); n++; end while (!r0_rdreq && n < 20);
    if (n >= 20) timeout("rd0");
    cyc();
    stim0(5'd2, 24'd0);
    wait_idle0();
    chk("t6_vec", 64'(vec0), 64'd0);
    chk("t6_fail", 64'(fail0), 64'd0);

    // Reset while stalled in writeback.
    m0_wait = 1'b1;
    push0(24'h00FF00, 24'h000000, 20'h00700);
    wait_write0();
    reset = 1'b1;
    cyc();
    chk("t7_write", 64'(m0_write), 64'd0);
    reset   = 1'b0;
    m0_wait = 1'b0;
    cyc();
    chk("t7_vec", 64'(vec0), 64'd0);
    chk("t7_ready", 64'(sc0_ready), 64'd1);

    // Wide build: three words per record, address wraps.
    exp1q.push_back({20'hFFFFF, 16'h1234});
    exp1q.push_back({20'h00000, 16'h5678});
    exp1q.push_back({20'h00001, 16'h9A80});
    push1(40'h123456789A, 40'h123456789A, 20'hFFFFF);
    wait_idle1();
    chk("w1_vec", 64'(vec1), 64'd1);
    chk("w1_fail", 64'(fail1), 64'd0);

    // Seventeen fails into a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      res1 = {8'(i + 1), 32'h0};
      exp1q.push_back({20'(i * 4),     8'(i + 1), 8'h00});
      exp1q.push_back({20'(i * 4 + 1), 16'h0000});
      exp1q.push_back({20'(i * 4 + 2), 16'h0081});
      push1(res1, 40'h0, 20'(i * 4));
      wait_idle1();
      if (i == 13) chk("w2_fail14", 64'(fail1), 64'hE);
    end
    chk("w2_fail_sat", 64'(fail1), 64'hF);
    chk("w2_vec_sat", 64'(vec1), 64'hF);
    chk("w2_accepts", 64'(acc1), 64'd54);

    repeat (3) cyc();
    chk("leftover0", 64'(exp0q.size()), 64'd0);
    chk("leftover1", 64'(exp1q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
